// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: bring-up and supervision controller for the ADC sequencer CSR.
// Waits for a stable PLL lock, stops the sequencer, recalibrates when needed,
// starts continuous conversion, and restarts the ADC when the response stream stalls.
module adc_seq_ctrl #(
  parameter int LOCK_CYCLES    = 1024,
  parameter int WDOG_CYCLES    = 4096,
  parameter int HOLDOFF_CYCLES = 256,
  parameter int POLL_INTERVAL  = 64,
  parameter int CAL_POLLS      = 255,
  parameter int READ_LATENCY   = 1
) (
  input  logic        clk50m,
  input  logic        reset_n,
  input  logic        pll_locked,
  input  logic        enable,
  input  logic        recal_req,
  input  logic        adc_resp_valid,
  output logic        csr_address,
  output logic        csr_read,
  input  logic [31:0] csr_readdata,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  output logic        running,
  output logic        fault,
  output logic [7:0]  restart_count
);

  localparam int LOCK_W  = $clog2(LOCK_CYCLES + 1);
  localparam int WDOG_W  = $clog2(WDOG_CYCLES + 1);
  localparam int HOLD_W  = $clog2(HOLDOFF_CYCLES + 1);
  localparam int TIMER_W = $clog2(POLL_INTERVAL + 1);
  localparam int POLLS_W = $clog2(CAL_POLLS + 1);

  localparam logic [31:0] CMD_STOP  = 32'h0000_0000;
  localparam logic [31:0] CMD_CAL   = 32'h0000_000F;
  localparam logic [31:0] CMD_START = 32'h0000_0001;

  typedef enum logic [2:0] {
    IDLE, LOCKWAIT, STOP, CAL, POLL, START, RUN, HOLDOFF
  } seqState_t;

  seqState_t          stateReg, stateNext;
  logic [LOCK_W-1:0]  lockCntReg, lockCntNext;
  logic [WDOG_W-1:0]  wdogReg, wdogNext;
  logic [HOLD_W-1:0]  holdCntReg, holdCntNext;
  logic [TIMER_W-1:0] pollTimerReg, pollTimerNext;
  logic [POLLS_W-1:0] pollCntReg, pollCntNext;
  logic               calPendingReg, calPendingNext;
  logic               stopToIdleReg, stopToIdleNext;
  logic               faultReg, faultNext;
  logic [7:0]         restartCntReg, restartCntNext;
  logic [31:0]        wrDataReg, wrDataNext;
  logic [7:0]         restartInc;
  logic               unusedReadBits;

  // Only the run-status bit of the command register is meaningful here.
  assign unusedReadBits = ^csr_readdata[31:1];

  assign restartInc = (restartCntReg == 8'hFF) ? 8'hFF : restartCntReg + 8'd1;

  // State and counter registers; reset leaves cal_pending set so the first start recalibrates.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      stateReg      <= IDLE;
      lockCntReg    <= '0;
      wdogReg       <= '0;
      holdCntReg    <= '0;
      pollTimerReg  <= '0;
      pollCntReg    <= '0;
      calPendingReg <= 1'b1;
      stopToIdleReg <= 1'b0;
      faultReg      <= 1'b0;
      restartCntReg <= '0;
      wrDataReg     <= '0;
    end else begin
      stateReg      <= stateNext;
      lockCntReg    <= lockCntNext;
      wdogReg       <= wdogNext;
      holdCntReg    <= holdCntNext;
      pollTimerReg  <= pollTimerNext;
      pollCntReg    <= pollCntNext;
      calPendingReg <= calPendingNext;
      stopToIdleReg <= stopToIdleNext;
      faultReg      <= faultNext;
      restartCntReg <= restartCntNext;
      wrDataReg     <= wrDataNext;
    end
  end

  // Next-state, counter and CSR write-data logic.
  always_comb begin
    stateNext      = stateReg;
    lockCntNext    = lockCntReg;
    wdogNext       = wdogReg;
    holdCntNext    = holdCntReg;
    pollTimerNext  = pollTimerReg;
    pollCntNext    = pollCntReg;
    // A recal request is remembered whatever the FSM is doing.
    calPendingNext = calPendingReg | recal_req;
    stopToIdleNext = stopToIdleReg;
    faultNext      = faultReg;
    restartCntNext = restartCntReg;
    wrDataNext     = wrDataReg;

    case (stateReg)
      IDLE: begin
        lockCntNext = '0;
        if (enable && pll_locked) stateNext = LOCKWAIT;
      end

      LOCKWAIT: begin
        if (!enable) begin
          stateNext   = IDLE;
          lockCntNext = '0;
        end else if (!pll_locked) begin
          lockCntNext = '0;
        end else if (lockCntReg == LOCK_W'(LOCK_CYCLES - 1)) begin
          stateNext      = STOP;
          stopToIdleNext = 1'b0;
          lockCntNext    = '0;
        end else begin
          lockCntNext = lockCntReg + LOCK_W'(1);
        end
      end

      STOP: begin
        if (stopToIdleReg) begin
          stateNext      = IDLE;
          stopToIdleNext = 1'b0;
          faultNext      = 1'b0;
        end else if (calPendingReg) begin
          stateNext = CAL;
        end else begin
          stateNext = START;
        end
      end

      CAL: begin
        // A request arriving in this very cycle survives the clear.
        calPendingNext = recal_req;
        pollTimerNext  = '0;
        pollCntNext    = '0;
        stateNext      = POLL;
      end

      POLL: begin
        pollTimerNext = (pollTimerReg == TIMER_W'(POLL_INTERVAL - 1)) ?
                        '0 : pollTimerReg + TIMER_W'(1);
        if (pollTimerReg == TIMER_W'(READ_LATENCY)) begin
          if (!csr_readdata[0]) begin
            stateNext = START;
          end else if (pollCntReg == POLLS_W'(CAL_POLLS - 1)) begin
            // Calibration never finished: keep it pending so the retry recalibrates.
            stateNext      = HOLDOFF;
            holdCntNext    = '0;
            faultNext      = 1'b1;
            restartCntNext = restartInc;
            calPendingNext = 1'b1;
          end else begin
            pollCntNext = pollCntReg + POLLS_W'(1);
          end
        end
      end

      START: begin
        wdogNext  = '0;
        stateNext = RUN;
      end

      RUN: begin
        wdogNext = adc_resp_valid ? '0 : wdogReg + WDOG_W'(1);
        if (!enable || !pll_locked) begin
          stateNext      = STOP;
          stopToIdleNext = 1'b1;
        end else if (wdogReg == WDOG_W'(WDOG_CYCLES - 1)) begin
          stateNext      = HOLDOFF;
          holdCntNext    = '0;
          faultNext      = 1'b1;
          restartCntNext = restartInc;
        end else if (recal_req || calPendingReg) begin
          calPendingNext = 1'b1;
          stateNext      = STOP;
          stopToIdleNext = 1'b0;
        end
      end

      HOLDOFF: begin
        if (!enable) begin
          stateNext      = STOP;
          stopToIdleNext = 1'b1;
        end else if (holdCntReg == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
          stateNext      = STOP;
          stopToIdleNext = 1'b0;
        end else begin
          holdCntNext = holdCntReg + HOLD_W'(1);
        end
      end

      default: stateNext = IDLE;
    endcase

    // Write data is loaded on entry to a write state and then held until the next write.
    case (stateNext)
      STOP:    wrDataNext = CMD_STOP;
      CAL:     wrDataNext = CMD_CAL;
      START:   wrDataNext = CMD_START;
      default: wrDataNext = wrDataReg;
    endcase
  end

  assign csr_address   = 1'b0;
  assign csr_read      = (stateReg == POLL) && (pollTimerReg == '0);
  assign csr_write     = (stateReg == STOP) || (stateReg == CAL) || (stateReg == START);
  assign csr_writedata = wrDataReg;
  assign running       = (stateReg == RUN);
  assign fault         = faultReg;
  assign restart_count = restartCntReg;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl: scenario tasks for adc_seq_ctrl with a CSR-write scoreboard.
module tb_adc_seq_ctrl;

  logic        clk50m = 1'b0;
  logic        reset_n = 1'b0;
  logic        pll_locked = 1'b0;
  logic        enable = 1'b0;
  logic        recal_req = 1'b0;
  logic        adc_resp_valid = 1'b0;
  logic        csr_address;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic        running;
  logic        fault;
  logic [7:0]  restart_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] expQ[$];
  logic        busy = 1'b0;
  logic [31:0] rdData = '0;
  int          readCount = 0;
  int          writeCount = 0;

  adc_seq_ctrl dut (
    .clk50m         (clk50m),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .enable         (enable),
    .recal_req      (recal_req),
    .adc_resp_valid (adc_resp_valid),
    .csr_address    (csr_address),
    .csr_read       (csr_read),
    .csr_readdata   (csr_readdata),
    .csr_write      (csr_write),
    .csr_writedata  (csr_writedata),
    .running        (running),
    .fault          (fault),
    .restart_count  (restart_count)
  );

  always #10 clk50m = ~clk50m;

  // Sequencer CSR model: one-cycle read latency, bit0 reports busy.
  assign csr_readdata = rdData;
  always @(posedge clk50m) begin
    if (csr_read) begin
      rdData    <= {31'b0, busy};
      readCount <= readCount + 1;
    end
  end

  // Scoreboard: every CSR write must match the next expected command.
  always @(negedge clk50m) begin
    logic [31:0] exp;
    if (reset_n && csr_write) begin
      writeCount++;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL csr_write_unexpected: got data %h, required no write", csr_writedata);
      end else begin
        exp = expQ.pop_front();
        if (csr_writedata !== exp) begin
          errors++;
          $display("FAIL csr_writedata: got %h, required %h", csr_writedata, exp);
        end else begin
          $display("write %h ok at %0t", csr_writedata, $time);
        end
      end
      checks++;
      if (csr_address !== 1'b0) begin
        errors++;
        $display("FAIL csr_address: got %b, required 0", csr_address);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk50m);
      #1;
    end
  endtask

  // Returns cycles until csr_write is seen, or -1 on timeout.
  task automatic wait_write(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk50m); #1;
      cycles++;
    end while (csr_write !== 1'b1 && cycles < limit);
    if (csr_write !== 1'b1) cycles = -1;
  endtask

  task automatic wait_running(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk50m); #1;
      cycles++;
    end while (running !== 1'b1 && cycles < limit);
    if (running !== 1'b1) cycles = -1;
  endtask

  task automatic wait_fault(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk50m); #1;
      cycles++;
    end while (fault !== 1'b1 && cycles < limit);
    if (fault !== 1'b1) cycles = -1;
  endtask

  task automatic wait_restart(input logic [7:0] target, input int limit, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk50m); #1;
      cycles++;
    end while (restart_count !== target && cycles < limit);
    if (restart_count !== target) cycles = -1;
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if ({csr_address, csr_read, csr_write, running, fault} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 00000", {csr_address, csr_read, csr_write, running, fault});
    end
    checks++;
    if (csr_writedata !== 32'h0) begin
      errors++;
      $display("FAIL reset_writedata: got %h, required 0", csr_writedata);
    end
    checks++;
    if (restart_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_restart_count: got %0d, required 0", restart_count);
    end
    reset_n = 1'b1;
    pll_locked = 1'b1;
    adc_resp_valid = 1'b1;
    tick(5);
    checks++;
    if (csr_write !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_enable: got write=%b running=%b, required 0 0", csr_write, running);
    end
    $display("test_reset done");
  endtask

  task automatic test_bringup();
    int cyc;
    int rd0;
    expQ.push_back(32'h0);
    expQ.push_back(32'hF);
    expQ.push_back(32'h1);
    rd0 = readCount;
    enable = 1'b1;
    wait_write(1100, cyc);
    checks++;
    if (cyc != 1025) begin
      errors++;
      $display("FAIL bringup_stop_latency: got %0d, required 1025", cyc);
    end
    tick(1);
    checks++;
    if (csr_write !== 1'b1) begin
      errors++;
      $display("FAIL cal_follows_stop: got write=%b, required 1", csr_write);
    end
    tick(1);
    checks++;
    if (csr_read !== 1'b1) begin
      errors++;
      $display("FAIL first_poll_read: got %b, required 1", csr_read);
    end
    wait_write(10, cyc);
    checks++;
    if (cyc != 2) begin
      errors++;
      $display("FAIL start_after_poll: got %0d, required 2", cyc);
    end
    tick(1);
    checks++;
    if (running !== 1'b1 || readCount - rd0 != 1) begin
      errors++;
      $display("FAIL bringup_run: got running=%b reads=%0d, required 1 1", running, readCount - rd0);
    end
    $display("test_bringup done");
  endtask

  task automatic test_lock_glitch();
    int cyc;
    expQ.push_back(32'h0);
    enable = 1'b0;
    wait_write(5, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL disable_stop: got %0d, required 1", cyc);
    end
    tick(3);
    expQ.push_back(32'h0);
    expQ.push_back(32'h1);
    enable = 1'b1;
    tick(501);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    wait_write(1100, cyc);
    checks++;
    if (cyc != 1024) begin
      errors++;
      $display("FAIL lock_glitch_latency: got %0d, required 1024", cyc);
    end
    wait_write(5, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL start_without_cal: got %0d, required 1", cyc);
    end
    tick(1);
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL lock_glitch_run: got %b, required 1", running);
    end
    $display("test_lock_glitch done");
  endtask

  task automatic test_watchdog();
    int cyc;
    expQ.push_back(32'h0);
    expQ.push_back(32'h1);
    adc_resp_valid = 1'b0;
    wait_fault(4200, cyc);
    checks++;
    if (cyc != 4096) begin
      errors++;
      $display("FAIL wdog_latency: got %0d, required 4096", cyc);
    end
    checks++;
    if (restart_count !== 8'd1 || running !== 1'b0) begin
      errors++;
      $display("FAIL wdog_fault_state: got count=%0d running=%b, required 1 0", restart_count, running);
    end
    adc_resp_valid = 1'b1;
    wait_write(300, cyc);
    checks++;
    if (cyc != 256) begin
      errors++;
      $display("FAIL holdoff_length: got %0d, required 256", cyc);
    end
    wait_write(5, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL restart_no_cal: got %0d, required 1", cyc);
    end
    tick(1);
    checks++;
    if (running !== 1'b1 || fault !== 1'b1) begin
      errors++;
      $display("FAIL wdog_rerun: got running=%b fault=%b, required 1 1", running, fault);
    end
    $display("test_watchdog done");
  endtask

  task automatic test_recal();
    int cyc;
    int rd0;
    expQ.push_back(32'h0);
    expQ.push_back(32'hF);
    expQ.push_back(32'h1);
    rd0 = readCount;
    recal_req = 1'b1;
    tick(1);
    recal_req = 1'b0;
    checks++;
    if (running !== 1'b0 || csr_write !== 1'b1) begin
      errors++;
      $display("FAIL recal_stop: got running=%b write=%b, required 0 1", running, csr_write);
    end
    wait_write(5, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL recal_cal: got %0d, required 1", cyc);
    end
    wait_write(10, cyc);
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("FAIL recal_start: got %0d, required 3", cyc);
    end
    tick(1);
    checks++;
    if (running !== 1'b1 || readCount - rd0 != 1) begin
      errors++;
      $display("FAIL recal_run: got running=%b reads=%0d, required 1 1", running, readCount - rd0);
    end
    $display("test_recal done");
  endtask

  task automatic test_cal_timeout();
    int cyc;
    int rd0;
    busy = 1'b1;
    expQ.push_back(32'h0);
    expQ.push_back(32'hF);
    expQ.push_back(32'h0);
    expQ.push_back(32'hF);
    expQ.push_back(32'h1);
    rd0 = readCount;
    recal_req = 1'b1;
    tick(1);
    recal_req = 1'b0;
    wait_restart(8'd2, 17000, cyc);
    checks++;
    if (cyc < 0 || readCount - rd0 != 255) begin
      errors++;
      $display("FAIL cal_timeout_polls: got cycles=%0d reads=%0d, required reads 255", cyc, readCount - rd0);
    end
    busy = 1'b0;
    wait_write(300, cyc);
    checks++;
    if (cyc != 256) begin
      errors++;
      $display("FAIL cal_holdoff: got %0d, required 256", cyc);
    end
    wait_write(5, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL cal_retry: got %0d, required 1", cyc);
    end
    wait_write(10, cyc);
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("FAIL cal_retry_start: got %0d, required 3", cyc);
    end
    tick(1);
    checks++;
    if (running !== 1'b1 || fault !== 1'b1) begin
      errors++;
      $display("FAIL cal_retry_run: got running=%b fault=%b, required 1 1", running, fault);
    end
    $display("test_cal_timeout done");
  endtask

  task automatic test_enable_wdog_same_cycle();
    int cyc;
    int wc0;
    expQ.push_back(32'h0);
    enable = 1'b0;
    wait_write(5, cyc);
    tick(2);
    checks++;
    if (fault !== 1'b0 || restart_count !== 8'd2) begin
      errors++;
      $display("FAIL idle_clears_fault: got fault=%b count=%0d, required 0 2", fault, restart_count);
    end
    expQ.push_back(32'h0);
    expQ.push_back(32'h1);
    enable = 1'b1;
    wait_running(1200, cyc);
    checks++;
    if (cyc != 1027) begin
      errors++;
      $display("FAIL rerun_latency: got %0d, required 1027", cyc);
    end
    adc_resp_valid = 1'b0;
    tick(4095);
    wc0 = writeCount;
    expQ.push_back(32'h0);
    enable = 1'b0;
    wait_write(5, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL same_cycle_stop: got %0d, required 1", cyc);
    end
    adc_resp_valid = 1'b1;
    tick(300);
    checks++;
    if (fault !== 1'b0 || restart_count !== 8'd2 || running !== 1'b0 || writeCount - wc0 != 1) begin
      errors++;
      $display("FAIL same_cycle_idle: got fault=%b count=%0d running=%b writes=%0d, required 0 2 0 1",
               fault, restart_count, running, writeCount - wc0);
    end
    $display("test_enable_wdog_same_cycle done");
  endtask

  task automatic test_async_reset();
    int cyc;
    expQ.push_back(32'h0);
    expQ.push_back(32'h1);
    enable = 1'b1;
    wait_running(1200, cyc);
    @(negedge clk50m);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (running !== 1'b0 || restart_count !== 8'd0 || csr_writedata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got running=%b count=%0d data=%h, required 0 0 0",
               running, restart_count, csr_writedata);
    end
    tick(3);
    expQ.push_back(32'h0);
    expQ.push_back(32'hF);
    expQ.push_back(32'h1);
    reset_n = 1'b1;
    wait_write(1100, cyc);
    checks++;
    if (cyc != 1025) begin
      errors++;
      $display("FAIL post_reset_stop: got %0d, required 1025", cyc);
    end
    wait_write(5, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL post_reset_cal: got %0d, required 1", cyc);
    end
    wait_write(10, cyc);
    tick(1);
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_run: got %b, required 1", running);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_glitch();
    test_watchdog();
    test_recal();
    test_cal_timeout();
    test_enable_wdog_same_cycle();
    test_async_reset();
    tick(2);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d pending, required 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
